parity_stream_checker: RTL and testbench

//   Registered, parametrised parity checker for the pressure-sensor word stream.
//   - Checks each valid DATA_W-bit word, parity bit included, against odd or even parity.
//   - Forwards the payload with a per-word verdict one clock later.
//   - Keeps a saturating error counter and a sticky error flag for the status path.
//   - Sits between the sensor word receiver and the pressure processing logic.
//

---
 rtl/parity_stream_checker.sv | 155 +++++++++++++++
 tb/tb_parity_stream_checker.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/parity_stream_checker.sv
`default_nettype none
// ============================================================================
// Module   : parity_stream_checker
// Purpose  : Registered parity checker for the pressure-sensor word stream.
//            Each valid DATA_W-bit word (parity bit at [DATA_W-1]) is checked
//            against odd or even parity. The payload and a per-word verdict
//            are forwarded one clock later. A saturating error counter and a
//            sticky error flag feed the status path.
//
// Parameters
//   DATA_W     word width including parity bit (2..32)
//   CNT_W      error counter / run counter width (1..16)
//   ALARM_RUN  consecutive bad words that raise alarm (1..2^CNT_W-1)
//
// Ports
//   clk              in   rising-edge clock
//   rst              in   synchronous active-high reset
//   in_valid_i       in   in_data_i carries a valid word
//   in_data_i        in   payload [DATA_W-2:0], parity bit [DATA_W-1]
//   odd_mode_i       in   1 = odd parity expected, 0 = even
//   clr_cnt_i        in   clears err_count, err_sticky and the run count
//   out_valid_o      out  out_* describe one checked word
//   out_payload_o    out  registered payload
//   out_not_error_o  out  1 = parity correct for that word
//   err_count_o      out  saturating count of bad words
//   err_sticky_o     out  set by a bad word, held until clr_cnt_i or rst
//   alarm_o          out  consecutive-error alarm
//
// Configuration macro
//   PARITY_CHECKER_ALARM_EN : when defined, a consecutive-bad-word run counter
//                             drives alarm_o; otherwise alarm_o is tied to 0.
//
// Revision : 1.0  initial release
// ============================================================================
module parity_stream_checker #(
   parameter int DATA_W    = 6,
   parameter int CNT_W     = 8,
   parameter int ALARM_RUN = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid_i,
   input  logic [DATA_W-1:0] in_data_i,
   input  logic              odd_mode_i,
   input  logic              clr_cnt_i,
   output logic              out_valid_o,
   output logic [DATA_W-2:0] out_payload_o,
   output logic              out_not_error_o,
   output logic [CNT_W-1:0]  err_count_o,
   output logic              err_sticky_o,
   output logic              alarm_o
);

   localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

   logic              out_valid_q;
   logic [DATA_W-2:0] payload_q;
   logic              not_error_q;
   logic [CNT_W-1:0]  err_count_q;
   logic [CNT_W-1:0]  err_count_d;
   logic              err_sticky_q;
   logic              err_sticky_d;

   logic word_parity;
   logic word_good;
   logic word_bad;

   // Reduction XOR over the whole word, parity bit included: odd parity is
   // satisfied when the count of ones is odd, i.e. the XOR is 1.
   assign word_parity = ^in_data_i;
   assign word_good   = odd_mode_i ? word_parity : ~word_parity;
   assign word_bad    = in_valid_i & ~word_good;

   // The clear takes effect first so a word arriving with clr_cnt_i is
   // counted against a freshly cleared counter.
   always_comb begin
      err_count_d  = clr_cnt_i ? '0 : err_count_q;
      err_sticky_d = clr_cnt_i ? 1'b0 : err_sticky_q;
      if (word_bad) begin
         if (err_count_d != c_cnt_max) begin
            err_count_d = err_count_d + CNT_W'(1);
         end
         err_sticky_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q  <= 1'b0;
         payload_q    <= '0;
         not_error_q  <= 1'b0;
         err_count_q  <= '0;
         err_sticky_q <= 1'b0;
      end else begin
         out_valid_q <= in_valid_i;
         // Payload and verdict hold their last values across idle cycles.
         if (in_valid_i) begin
            payload_q   <= in_data_i[DATA_W-2:0];
            not_error_q <= word_good;
         end
         err_count_q  <= err_count_d;
         err_sticky_q <= err_sticky_d;
      end
   end

   assign out_valid_o     = out_valid_q;
   assign out_payload_o   = payload_q;
   assign out_not_error_o = not_error_q;
   assign err_count_o     = err_count_q;
   assign err_sticky_o    = err_sticky_q;

`ifdef PARITY_CHECKER_ALARM_EN
   localparam logic [CNT_W-1:0] c_alarm_run = CNT_W'(ALARM_RUN);

   logic [CNT_W-1:0] run_q;
   logic [CNT_W-1:0] run_d;
   logic             alarm_q;
   logic             alarm_d;

   // Only valid words move the run: idle cycles leave it untouched, a good
   // word restarts it, a bad word extends it (saturating).
   always_comb begin
      run_d = clr_cnt_i ? '0 : run_q;
      if (in_valid_i) begin
         if (word_bad) begin
            if (run_d != c_cnt_max) begin
               run_d = run_d + CNT_W'(1);
            end
         end else begin
            run_d = '0;
         end
      end
      alarm_d = (run_d >= c_alarm_run);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         run_q   <= '0;
         alarm_q <= 1'b0;
      end else begin
         run_q   <= run_d;
         alarm_q <= alarm_d;
      end
   end

   assign alarm_o = alarm_q;
`else
   // Keeps ALARM_RUN referenced when the alarm logic is compiled out.
   logic unused_alarm_cfg;
   assign unused_alarm_cfg = (ALARM_RUN != 0);
   assign alarm_o          = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_parity_stream_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_parity_stream_checker
// Purpose  : Self-checking bench for parity_stream_checker. Three instances
//            share one stimulus stream:
//              inst 0 : DATA_W=6, CNT_W=8
//              inst 1 : DATA_W=6, CNT_W=2 (counter saturation)
//              inst 2 : DATA_W=9, CNT_W=8
//            Expected per-word results are queued when a word is driven and
//            popped when the DUT presents out_valid; counters, sticky flag and
//            alarm are compared against a reference model every cycle.
// Revision : 1.0  initial release
// ============================================================================
module tb_parity_stream_checker;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic [8:0] din;
   logic       odd_mode;
   logic       clr_cnt;

   logic       ov_a, ov_b, ov_c;
   logic [4:0] pay_a, pay_b;
   logic [7:0] pay_c;
   logic       ne_a, ne_b, ne_c;
   logic [7:0] cnt_a, cnt_c;
   logic [1:0] cnt_b;
   logic       st_a, st_b, st_c;
   logic       al_a, al_b, al_c;

   parity_stream_checker #(.DATA_W(6), .CNT_W(8), .ALARM_RUN(3)) u_dut_a (
      .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_data_i(din[5:0]),
      .odd_mode_i(odd_mode), .clr_cnt_i(clr_cnt), .out_valid_o(ov_a),
      .out_payload_o(pay_a), .out_not_error_o(ne_a), .err_count_o(cnt_a),
      .err_sticky_o(st_a), .alarm_o(al_a));

   parity_stream_checker #(.DATA_W(6), .CNT_W(2), .ALARM_RUN(3)) u_dut_b (
      .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_data_i(din[5:0]),
      .odd_mode_i(odd_mode), .clr_cnt_i(clr_cnt), .out_valid_o(ov_b),
      .out_payload_o(pay_b), .out_not_error_o(ne_b), .err_count_o(cnt_b),
      .err_sticky_o(st_b), .alarm_o(al_b));

   parity_stream_checker #(.DATA_W(9), .CNT_W(8), .ALARM_RUN(3)) u_dut_c (
      .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_data_i(din),
      .odd_mode_i(odd_mode), .clr_cnt_i(clr_cnt), .out_valid_o(ov_c),
      .out_payload_o(pay_c), .out_not_error_o(ne_c), .err_count_o(cnt_c),
      .err_sticky_o(st_c), .alarm_o(al_c));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int inst;
      int pay;
      int ne;
   } exp_t;

   exp_t sbq[$];

   int n_pass  = 0;
   int n_total = 0;

   int c_max[3] = '{255, 3, 255};
   int m_cnt[3];
   int m_st[3];
   int m_run[3];
   int m_al[3];
   int m_ov[3];
   int m_pay[3];
   int m_ne[3];

   task automatic check(input string tag, input int got, input int exp);
      n_total++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   function automatic int dut_val(input int k, input int which);
      // which: 0 ov, 1 pay, 2 ne, 3 cnt, 4 sticky, 5 alarm
      case (which)
         0: return (k == 0) ? int'(ov_a)  : (k == 1) ? int'(ov_b)  : int'(ov_c);
         1: return (k == 0) ? int'(pay_a) : (k == 1) ? int'(pay_b) : int'(pay_c);
         2: return (k == 0) ? int'(ne_a)  : (k == 1) ? int'(ne_b)  : int'(ne_c);
         3: return (k == 0) ? int'(cnt_a) : (k == 1) ? int'(cnt_b) : int'(cnt_c);
         4: return (k == 0) ? int'(st_a)  : (k == 1) ? int'(st_b)  : int'(st_c);
         default: return (k == 0) ? int'(al_a) : (k == 1) ? int'(al_b) : int'(al_c);
      endcase
   endfunction

   // Drive one cycle of stimulus, advance the reference model, then compare
   // one time unit after the rising edge.
   task automatic step(input logic v, input logic [8:0] d, input logic odd,
                       input logic clr, input logic r, input string tag);
      in_valid = v;
      din      = d;
      odd_mode = odd;
      clr_cnt  = clr;
      rst      = r;
      for (int k = 0; k < 3; k++) begin
         int par, good, bad, pay;
         par  = (k < 2) ? int'(^d[5:0]) : int'(^d[8:0]);
         pay  = (k < 2) ? int'(d[4:0])  : int'(d[7:0]);
         good = odd ? par : 1 - par;
         bad  = (v && good == 0) ? 1 : 0;
         if (r) begin
            m_cnt[k] = 0; m_st[k] = 0; m_run[k] = 0; m_al[k] = 0;
            m_ov[k]  = 0; m_pay[k] = 0; m_ne[k] = 0;
         end else begin
            if (clr) begin
               m_cnt[k] = 0; m_st[k] = 0; m_run[k] = 0;
            end
            if (bad == 1) begin
               if (m_cnt[k] < c_max[k]) m_cnt[k]++;
               m_st[k] = 1;
            end
            if (v) begin
               if (bad == 1) begin
                  if (m_run[k] < c_max[k]) m_run[k]++;
               end else begin
                  m_run[k] = 0;
               end
               m_pay[k] = pay;
               m_ne[k]  = good;
               sbq.push_back('{inst: k, pay: pay, ne: good});
            end
            m_al[k] = (m_run[k] >= 3) ? 1 : 0;
            m_ov[k] = v ? 1 : 0;
         end
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         string t;
         int    exp_al;
         t = $sformatf("%s[%0d]", tag, k);
`ifdef PARITY_CHECKER_ALARM_EN
         exp_al = m_al[k];
`else
         exp_al = 0;
`endif
         check({t, ".out_valid"}, dut_val(k, 0), m_ov[k]);
         if (dut_val(k, 0) == 1) begin
            if (sbq.size() == 0) begin
               check({t, ".sb_empty"}, 1, 0);
            end else begin
               exp_t e;
               e = sbq.pop_front();
               check({t, ".sb_inst"}, k, e.inst);
               check({t, ".payload"}, dut_val(k, 1), e.pay);
               check({t, ".not_error"}, dut_val(k, 2), e.ne);
            end
         end else begin
            check({t, ".payload_hold"}, dut_val(k, 1), m_pay[k]);
            check({t, ".not_error_hold"}, dut_val(k, 2), m_ne[k]);
         end
         check({t, ".err_count"}, dut_val(k, 3), m_cnt[k]);
         check({t, ".err_sticky"}, dut_val(k, 4), m_st[k]);
         check({t, ".alarm"}, dut_val(k, 5), exp_al);
      end
   endtask

   localparam logic [8:0] GOOD_ODD = 9'b000000001;  // one set bit
   localparam logic [8:0] BAD_ODD  = 9'b000000011;  // two set bits

   initial begin
      in_valid = 1'b0; din = '0; odd_mode = 1'b1; clr_cnt = 1'b0; rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         m_cnt[k] = 0; m_st[k] = 0; m_run[k] = 0; m_al[k] = 0;
         m_ov[k] = 0; m_pay[k] = 0; m_ne[k] = 0;
      end

      // Reset state
      step(1'b0, '0, 1'b1, 1'b0, 1'b1, "reset");
      step(1'b0, '0, 1'b1, 1'b0, 1'b1, "reset2");
      check("reset.err_count", int'(cnt_a), 0);

      // Odd parity, good then bad word
      step(1'b1, GOOD_ODD, 1'b1, 1'b0, 1'b0, "t1_good");
      check("t1.payload_const", int'(pay_a), 1);
      check("t1.not_error_const", int'(ne_a), 1);
      step(1'b1, BAD_ODD, 1'b1, 1'b0, 1'b0, "t1_bad");
      check("t1.err_count_const", int'(cnt_a), 1);
      check("t1.sticky_const", int'(st_a), 1);

      // Even parity accepts the same data; switching back to odd rejects it
      step(1'b1, BAD_ODD, 1'b0, 1'b0, 1'b0, "t2_even");
      step(1'b1, BAD_ODD, 1'b1, 1'b0, 1'b0, "t2_odd");
      step(1'b0, '0, 1'b1, 1'b0, 1'b0, "t2_idle");

      // Saturation of the 2-bit counter, then clear together with a bad word
      step(1'b0, '0, 1'b1, 1'b1, 1'b0, "t3_clr");
      for (int i = 0; i < 5; i++) step(1'b1, BAD_ODD, 1'b1, 1'b0, 1'b0, "t3_bad");
      check("t3.cnt_sat_const", int'(cnt_b), 3);
      step(1'b1, BAD_ODD, 1'b1, 1'b1, 1'b0, "t3_clr_bad");
      check("t3.clr_bad_cnt_const", int'(cnt_b), 1);
      step(1'b1, GOOD_ODD, 1'b1, 1'b1, 1'b0, "t3_clr_good");
      check("t3.clr_good_sticky_const", int'(st_a), 0);

      // Alarm: bad,bad,idle,bad then good; bad,bad,good,bad
      step(1'b0, '0, 1'b1, 1'b1, 1'b0, "t4_clr");
      step(1'b1, BAD_ODD, 1'b1, 1'b0, 1'b0, "t4_b1");
      step(1'b1, BAD_ODD, 1'b1, 1'b0, 1'b0, "t4_b2");
      step(1'b0, '0, 1'b1, 1'b0, 1'b0, "t4_idle");
      step(1'b1, BAD_ODD, 1'b1, 1'b0, 1'b0, "t4_b3");
      step(1'b0, '0, 1'b1, 1'b0, 1'b0, "t4_hold");
      step(1'b1, GOOD_ODD, 1'b1, 1'b0, 1'b0, "t4_good");
      step(1'b1, BAD_ODD, 1'b1, 1'b0, 1'b0, "t4_c1");
      step(1'b1, BAD_ODD, 1'b1, 1'b0, 1'b0, "t4_c2");
      step(1'b1, GOOD_ODD, 1'b1, 1'b0, 1'b0, "t4_c3");
      step(1'b1, BAD_ODD, 1'b1, 1'b0, 1'b0, "t4_c4");
      // Clear with a bad word during a long run leaves run at 1
      step(1'b1, BAD_ODD, 1'b1, 1'b0, 1'b0, "t4_d1");
      step(1'b1, BAD_ODD, 1'b1, 1'b0, 1'b0, "t4_d2");
      step(1'b1, BAD_ODD, 1'b1, 1'b1, 1'b0, "t4_d3");

      // Reset mid-stream drops the word in flight
      step(1'b1, BAD_ODD, 1'b1, 1'b0, 1'b0, "t5_pre");
      step(1'b1, BAD_ODD, 1'b1, 1'b0, 1'b1, "t5_rst");
      check("t5.out_valid_const", int'(ov_a), 0);
      step(1'b1, BAD_ODD, 1'b1, 1'b0, 1'b0, "t5_post");

      // Random stream
      for (int i = 0; i < 1000; i++) begin
         step(($urandom_range(0, 3) != 0), 9'($urandom), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 39) == 0), 1'b0, "rand");
      end
      step(1'b0, '0, 1'b1, 1'b0, 1'b0, "drain");
      check("sb.final_empty", sbq.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
